// File: rtl/is_uart_tx_fifo.sv
// is_uart_tx_fifo: first-word-fall-through byte buffer between the main FSM and the UART transmit side.
module is_uart_tx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 12
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     flush_i,
    input  logic                     wr_vld_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    output logic                     wr_rdy_o,
    output logic                     tx_rdy_t_o,
    output logic [DATA_W-1:0]        tx_data_r_o,
    input  logic                     tx_rdy_r_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     afull_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF   = (AW+1)'(AF_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       cnt;
    logic              wr_en, rd_en;

    assign wr_rdy_o    = (cnt != FULL) && !flush_i;
    assign tx_rdy_t_o  = cnt != '0;
    assign tx_data_r_o = tx_rdy_t_o ? mem[rd_ptr] : '0;
    assign count_o     = cnt;
    assign afull_o     = cnt >= AF;
    assign empty_o     = cnt == '0;
    assign wr_en       = wr_vld_i && wr_rdy_o;
    assign rd_en       = tx_rdy_t_o && tx_rdy_r_i && !flush_i;

    // Storage is left unreset; the output mux hides stale entries.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en != rd_en) cnt <= wr_en ? cnt + 1'b1 : cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_is_uart_tx_fifo.sv
// tb_is_uart_tx_fifo: vector table plus queue scoreboard for the transmit FIFO.
module tb_is_uart_tx_fifo;
    logic       clk_i = 0, rstn_i = 0, flush_i = 0, wr_vld_i = 0, tx_rdy_r_i = 0;
    logic [7:0] wr_data_i = 0, tx_data_r_o;
    logic       wr_rdy_o, tx_rdy_t_o, afull_o, empty_o;
    logic [4:0] count_o;
    int         errors = 0, checks = 0, rx_n = 0;
    logic [7:0] q[$];

    typedef struct {
        logic       fl, wv;
        logic [7:0] wd;
        logic       rr, e_wr, e_t;
        logic [7:0] e_d;
        logic [4:0] e_c;
        logic       e_af, e_e;
    } vec_t;
    vec_t tv[12];

    is_uart_tx_fifo #(.DATA_W(8), .DEPTH(16), .AF_LVL(12)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .wr_vld_i(wr_vld_i),
        .wr_data_i(wr_data_i), .wr_rdy_o(wr_rdy_o), .tx_rdy_t_o(tx_rdy_t_o),
        .tx_data_r_o(tx_data_r_o), .tx_rdy_r_i(tx_rdy_r_i), .count_o(count_o),
        .afull_o(afull_o), .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: a queue model of the FIFO, checked every cycle away from the clock edge.
    always @(negedge clk_i) begin
        if (!rstn_i) q.delete();
        else begin
            logic full;
            full = q.size() == 16;
            chk("mon_wr_rdy", 32'(wr_rdy_o), 32'(!full && !flush_i));
            chk("mon_tx_rdy", 32'(tx_rdy_t_o), 32'(q.size() != 0));
            chk("mon_count", 32'(count_o), 32'(q.size()));
            chk("mon_afull", 32'(afull_o), 32'(q.size() >= 12));
            chk("mon_empty", 32'(empty_o), 32'(q.size() == 0));
            if (q.size() == 0) chk("mon_idle_data", 32'(tx_data_r_o), 32'(0));
            if (flush_i) q.delete();
            else begin
                if (q.size() != 0 && tx_rdy_r_i) begin
                    chk("mon_order", 32'(tx_data_r_o), 32'(q[0]));
                    void'(q.pop_front());
                    rx_n++;
                end
                if (wr_vld_i && !full) q.push_back(wr_data_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // mode 0: reader always ready; mode 1: reader toggles every 3 cycles
    task automatic stream(input logic [7:0] base, input int n, input int mode);
        int idx = 0, cyc = 0;
        while ((idx < n || !empty_o) && cyc < 1000) begin
            wr_vld_i   = idx < n;
            wr_data_i  = base + 8'(idx);
            tx_rdy_r_i = mode == 0 ? 1'b1 : ((cyc / 3) % 2 == 0);
            @(negedge clk_i);
            if (wr_vld_i && wr_rdy_o) idx++;
            tick();
            cyc++;
        end
        chk("stream_done", 32'(cyc < 1000), 32'(1));
        wr_vld_i = 0;
        tx_rdy_r_i = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int r0;
        tv[0]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 0, 1};
        tv[1]  = '{0, 1, 8'hA5, 0, 1, 0, 8'h00, 5'd0, 0, 1};
        tv[2]  = '{0, 1, 8'h5A, 1, 1, 1, 8'hA5, 5'd1, 0, 0};
        tv[3]  = '{0, 0, 8'h00, 0, 1, 1, 8'h5A, 5'd1, 0, 0};
        tv[4]  = '{0, 1, 8'h33, 0, 1, 1, 8'h5A, 5'd1, 0, 0};
        tv[5]  = '{1, 1, 8'h77, 1, 0, 1, 8'h5A, 5'd2, 0, 0};
        tv[6]  = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 0, 1};
        tv[7]  = '{0, 1, 8'h48, 1, 1, 0, 8'h00, 5'd0, 0, 1};
        tv[8]  = '{0, 1, 8'h65, 1, 1, 1, 8'h48, 5'd1, 0, 0};
        tv[9]  = '{0, 1, 8'h6C, 1, 1, 1, 8'h65, 5'd1, 0, 0};
        tv[10] = '{0, 0, 8'h00, 1, 1, 1, 8'h6C, 5'd1, 0, 0};
        tv[11] = '{0, 0, 8'h00, 0, 1, 0, 8'h00, 5'd0, 0, 1};

        repeat (3) tick();
        rstn_i = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            chk("idle_wr_rdy", 32'(wr_rdy_o), 32'(1));
            chk("idle_tx_rdy", 32'(tx_rdy_t_o), 32'(0));
            chk("idle_data", 32'(tx_data_r_o), 32'(0));
            chk("idle_count", 32'(count_o), 32'(0));
            chk("idle_empty", 32'(empty_o), 32'(1));
            tick();
        end

        for (int i = 0; i < 12; i++) begin
            flush_i = tv[i].fl; wr_vld_i = tv[i].wv; wr_data_i = tv[i].wd; tx_rdy_r_i = tv[i].rr;
            @(negedge clk_i);
            chk($sformatf("vec%0d_wr_rdy", i), 32'(wr_rdy_o), 32'(tv[i].e_wr));
            chk($sformatf("vec%0d_tx_rdy", i), 32'(tx_rdy_t_o), 32'(tv[i].e_t));
            chk($sformatf("vec%0d_data", i), 32'(tx_data_r_o), 32'(tv[i].e_d));
            chk($sformatf("vec%0d_count", i), 32'(count_o), 32'(tv[i].e_c));
            chk($sformatf("vec%0d_afull", i), 32'(afull_o), 32'(tv[i].e_af));
            chk($sformatf("vec%0d_empty", i), 32'(empty_o), 32'(tv[i].e_e));
            tick();
        end
        flush_i = 0; wr_vld_i = 0; tx_rdy_r_i = 0;

        wr_vld_i = 1;
        for (int i = 0; i < 16; i++) begin
            wr_data_i = 8'(i);
            @(negedge clk_i);
            chk("fill_wr_rdy", 32'(wr_rdy_o), 32'(1));
            chk("fill_afull", 32'(afull_o), 32'(i >= 12));
            tick();
        end
        wr_data_i = 8'h10;
        repeat (3) begin
            @(negedge clk_i);
            chk("full_wr_rdy", 32'(wr_rdy_o), 32'(0));
            chk("full_count", 32'(count_o), 32'(16));
            tick();
        end
        r0 = rx_n;
        tx_rdy_r_i = 1;
        @(negedge clk_i);
        chk("pulse_head", 32'(tx_data_r_o), 32'(8'h00));
        tick();
        tx_rdy_r_i = 0;
        @(negedge clk_i);
        chk("pulse_wr_rdy", 32'(wr_rdy_o), 32'(1));
        chk("pulse_count", 32'(count_o), 32'(15));
        tick();
        wr_data_i = 8'h11;
        @(negedge clk_i);
        chk("refull_wr_rdy", 32'(wr_rdy_o), 32'(0));
        chk("refull_head", 32'(tx_data_r_o), 32'(8'h01));
        tick();
        stream(8'h11, 1, 0);
        chk("fill_drain_n", 32'(rx_n - r0), 32'(18));

        r0 = rx_n;
        stream(8'h00, 40, 1);
        chk("wrap_n", 32'(rx_n - r0), 32'(40));

        wr_vld_i = 1;
        for (int i = 0; i < 5; i++) begin
            wr_data_i = 8'hE0 + 8'(i);
            tick();
        end
        wr_vld_i = 0;
        #2 rstn_i = 0;
        #1;
        chk("rst_count", 32'(count_o), 32'(0));
        chk("rst_tx_rdy", 32'(tx_rdy_t_o), 32'(0));
        chk("rst_data", 32'(tx_data_r_o), 32'(0));
        chk("rst_wr_rdy", 32'(wr_rdy_o), 32'(1));
        chk("rst_empty", 32'(empty_o), 32'(1));
        chk("rst_afull", 32'(afull_o), 32'(0));
        @(negedge clk_i);
        tick();
        rstn_i = 1;
        wr_vld_i = 1;
        wr_data_i = 8'hC0;
        tick();
        wr_vld_i = 0;
        @(negedge clk_i);
        chk("post_rst_head", 32'(tx_data_r_o), 32'(8'hC0));
        chk("post_rst_count", 32'(count_o), 32'(1));
        tick();
        stream(8'h00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/is_uart_tx_fifo.md
# is_uart_tx_fifo

Transmit byte buffer between the main FSM and the UART controller's transmit side. It accepts bytes from the FSM over a valid/ready handshake, stores up to DEPTH bytes, and presents them in order to the controller. The FSM can then emit multi-byte messages (ROM strings, hex-to-ASCII echoes) without stalling on each byte's serialisation time. Output is first-word-fall-through.

## Interface
Parameters:
- DATA_W, 8: byte width, equal to the package DATA_W.
- DEPTH, 16: number of storage entries; must be a power of two and at least 2.
- AF_LVL, 12: almost-full threshold; 1 ≤ AF_LVL ≤ DEPTH.

Ports:
- clk_i, in, 1: system clock, the only clock.
- rstn_i, in, 1: asynchronous active-low reset (the synchronised sync_rstn from the top).
- flush_i, in, 1: synchronous flush; discards all stored bytes.
- wr_vld_i, in, 1: FSM has a byte on wr_data_i.
- wr_data_i, in, DATA_W: byte from the FSM.
- wr_rdy_o, out, 1: FIFO can accept a byte this cycle.
- tx_rdy_t_o, out, 1: byte available to the controller (drives controller tx_rdy_t_i).
- tx_data_r_o, out, DATA_W: head byte (drives controller tx_data_r_i).
- tx_rdy_r_i, in, 1: controller accepts the head byte (from controller tx_rdy_r_o).
- count_o, out, $clog2(DEPTH)+1: number of stored bytes.
- afull_o, out, 1: count_o ≥ AF_LVL.
- empty_o, out, 1: count_o == 0.

## Operation
- Storage is a DEPTH x DATA_W register array.
- Write pointer wr_ptr and read pointer rd_ptr are $clog2(DEPTH) bits each and wrap modulo DEPTH.
- Occupancy register cnt is $clog2(DEPTH)+1 bits, range 0..DEPTH.
- Write occurs when wr_vld_i && wr_rdy_o && !flush_i:
  - mem[wr_ptr] ← wr_data_i
  - wr_ptr ← wr_ptr+1
- Read occurs when tx_rdy_t_o && tx_rdy_r_i && !flush_i:
  - rd_ptr ← rd_ptr+1
- cnt update:
  - write only: cnt+1
  - read only: cnt−1
  - both, or neither: cnt unchanged
- wr_rdy_o = (cnt != DEPTH) && !flush_i. This is combinational from registers and flush_i. It does not depend on tx_rdy_r_i, so there is no write-through when full.
- tx_rdy_t_o = (cnt != 0).
- tx_data_r_o = mem[rd_ptr] when cnt != 0, otherwise 0. The output is never X after reset.
- Flush: when flush_i=1 at a clock edge, wr_ptr, rd_ptr and cnt go to 0.
  - Flush has priority over a simultaneous write and read; neither takes effect.
  - Memory contents are not cleared.
- Bytes are delivered in strict write order. There is no drop or overwrite path.
- Outputs after reset:
  - wr_rdy_o=1, tx_rdy_t_o=0, tx_data_r_o=0
  - count_o=0, afull_o=0, empty_o=1
  - All pointers are 0.
- Reset asserted mid-operation clears all stored bytes immediately (asynchronously), with the same output values as above.
- The same-cycle handshake on each port is valid/ready. A master must hold its valid and data stable until transfer. This block guarantees that for tx_rdy_t_o/tx_data_r_o: neither changes until a read or a flush.

## Timing
- Write-to-output latency: a byte written into an empty FIFO at edge N gives tx_rdy_t_o=1 and tx_data_r_o = that byte from cycle N+1.
- Full: after the DEPTH-th write at edge N, wr_rdy_o=0 from cycle N+1. It returns to 1 in the cycle after the first read.
- Empty: after the last read at edge N, tx_rdy_t_o=0 and tx_data_r_o=0 from cycle N+1.
- Simultaneous read and write at count=1:
  - count stays 1.
  - tx_data_r_o changes to the new byte in the next cycle.
- count_o, afull_o and empty_o are registered-derived and update in the cycle after the causing edge.
- Sustained throughput is one byte per clock in each direction.

## Test plan
- Reset, idle: after rstn_i release with no stimulus → wr_rdy_o=1, tx_rdy_t_o=0, tx_data_r_o=8'h00, count_o=0, empty_o=1, for 20 cycles.
- Ordered pass-through: tx_rdy_r_i=1 constantly; write 8'h48, 8'h65, 8'h6C → controller sees the same three bytes in that order, first valid one cycle after its write, count_o never exceeds 1.
- Fill and back-pressure (DEPTH=16, AF_LVL=12):
  - Stimulus: tx_rdy_r_i=0; write 8'h00..8'h11 continuously.
  - afull_o rises after the 12th write.
  - wr_rdy_o=0 after the 16th write.
  - 8'h10 and 8'h11 are held by the source and not lost.
  - Then pulse tx_rdy_r_i once → 8'h00 leaves, wr_rdy_o=1 for one cycle, 8'h10 accepted.
- Wrap-around: stream 40 incrementing bytes with tx_rdy_r_i toggling every 3 cycles → output sequence 0..39, no duplicates or gaps.
- Simultaneous events:
  - count=1 (byte 8'hA5) with read and write of 8'h5A in the same cycle → count_o stays 1, tx_data_r_o=8'h5A next cycle.
  - flush_i asserted with wr_vld_i and tx_rdy_r_i also high → next cycle count_o=0, tx_rdy_t_o=0, nothing written.
- Reset mid-stream: assert rstn_i low with 5 bytes stored → outputs immediately take reset values; after release, the first new write appears first at the output.
